// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
package cpu_pkg;

  localparam int INST_W = 8;
  localparam logic [INST_W-1:0] HALT_OPCODE_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: walks instruction_memory, registers each
// word and hands it to decode over valid/ready, with branch redirect and halt detect.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                IMEM_DEPTH  = 4,
  parameter int                RESET_PC    = 0,
  parameter logic [INST_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT,
  localparam int               AW          = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [AW-1:0]     PC_value,
  input  logic [INST_W-1:0] instruction,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              branch_valid,
  input  logic [AW-1:0]     branch_target,
  output logic              halted,
  output logic              busy,
  output logic [15:0]       fetch_count
);

  fetch_state_t      state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic [15:0]       count_q, count_d;

  logic              transfer;
  logic              load;
  logic [AW-1:0]     pc_inc;
  logic [AW-1:0]     branch_pc;

  assign transfer = valid_q & inst_ready;
  assign load     = (state_q == FETCH) & (~valid_q | inst_ready);

  // Explicit wrap compare keeps non-power-of-two depths legal.
  assign pc_inc    = (pc_q == AW'(IMEM_DEPTH - 1)) ? '0 : pc_q + AW'(1);
  assign branch_pc = (int'(branch_target) >= IMEM_DEPTH) ? '0 : branch_target;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q & ~inst_ready;
    count_d = count_q;

    if (transfer && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = AW'(RESET_PC);
          count_d = '0;
        end
      end
      FETCH: begin
        if (branch_valid) begin
          pc_d    = branch_pc;
          valid_d = 1'b0;
        end else if (load) begin
          if (instruction != HALT_OPCODE) begin
            inst_d  = instruction;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end else begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        if (branch_valid) begin
          state_d = FETCH;
          pc_d    = branch_pc;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= AW'(RESET_PC);
      inst_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign PC_value    = pc_q;
  assign inst_out    = inst_q;
  assign inst_valid  = valid_q;
  assign halted      = (state_q == HALT);
  assign busy        = (state_q == FETCH);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: expected words are queued as stimulus is set up and popped on each transfer.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst, start_a, start_b, inst_ready, branch_valid;
  logic [1:0] branch_target;

  logic [1:0]  pc_a, pc_b;
  logic [7:0]  instr_a, instr_b, out_a, out_b;
  logic        valid_a, valid_b, halted_a, halted_b, busy_a, busy_b;
  logic [15:0] count_a, count_b;

  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  logic       mon_b_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign instr_a = mem_a[pc_a];
  assign instr_b = mem_b[pc_b];

  fetch_sequencer #(.IMEM_DEPTH(4), .RESET_PC(0), .HALT_OPCODE(8'hFF)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .PC_value(pc_a), .instruction(instr_a),
    .inst_out(out_a), .inst_valid(valid_a), .inst_ready(inst_ready),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .halted(halted_a), .busy(busy_a), .fetch_count(count_a)
  );

  fetch_sequencer #(.IMEM_DEPTH(4), .RESET_PC(0), .HALT_OPCODE(8'h00)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .PC_value(pc_b), .instruction(instr_b),
    .inst_out(out_b), .inst_valid(valid_b), .inst_ready(inst_ready),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .halted(halted_b), .busy(busy_b), .fetch_count(count_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfers happen on the next rising edge when valid & ready are seen here.
  always @(negedge clk) begin
    if (!rst && valid_a) check("a_no_halt_word", {31'd0, out_a == 8'hFF}, 32'd0);
    if (!rst && valid_a && inst_ready) begin
      if (q_a.size() == 0) check("a_sb_underflow", 32'd1, 32'd0);
      else check("a_word", {24'd0, out_a}, {24'd0, q_a.pop_front()});
    end
    if (!rst && mon_b_en && valid_b && inst_ready) begin
      if (q_b.size() == 0) check("b_sb_underflow", 32'd1, 32'd0);
      else check("b_word", {24'd0, out_b}, {24'd0, q_b.pop_front()});
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_halted_a(input int max_cycles);
    int i;
    for (i = 0; i < max_cycles && !halted_a; i++) tick();
    if (!halted_a) check("a_halt_timeout", 32'd1, 32'd0);
  endtask

  task automatic start_pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; inst_ready = 1'b0;
    branch_valid = 1'b0; branch_target = 2'd0; mon_b_en = 1'b1;
    mem_a = '{8'h11, 8'h22, 8'hFF, 8'h44};
    mem_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    tick();
    do_reset();

    check("rst_valid",  {31'd0, valid_a},  32'd0);
    check("rst_pc",     {30'd0, pc_a},     32'd0);
    check("rst_out",    {24'd0, out_a},    32'd0);
    check("rst_halted", {31'd0, halted_a}, 32'd0);
    check("rst_busy",   {31'd0, busy_a},   32'd0);
    check("rst_count",  {16'd0, count_a},  32'd0);

    // 1: straight-line run to halt opcode
    q_a.push_back(8'h11); q_a.push_back(8'h22);
    inst_ready = 1'b1;
    start_pulse_a();
    check("t1_busy_n1",  {31'd0, busy_a},  32'd1);
    check("t1_valid_n1", {31'd0, valid_a}, 32'd0);
    tick();
    check("t1_valid_n2", {31'd0, valid_a}, 32'd1);
    check("t1_first",    {24'd0, out_a},   32'h11);
    wait_halted_a(20);
    check("t1_halted", {31'd0, halted_a}, 32'd1);
    check("t1_pc",     {30'd0, pc_a},     32'd2);
    check("t1_valid",  {31'd0, valid_a},  32'd0);
    check("t1_count",  {16'd0, count_a},  32'd2);
    check("t1_sb_empty", q_a.size(), 32'd0);

    // 2: stall holds output and PC
    do_reset();
    inst_ready = 1'b0;
    q_a.push_back(8'h11); q_a.push_back(8'h22);
    start_pulse_a();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_stall_out",   {24'd0, out_a},   32'h11);
      check("t2_stall_valid", {31'd0, valid_a}, 32'd1);
      check("t2_stall_pc",    {30'd0, pc_a},    32'd1);
    end
    inst_ready = 1'b1;
    tick();
    check("t2_next", {24'd0, out_a}, 32'h22);
    wait_halted_a(20);
    check("t2_count", {16'd0, count_a}, 32'd2);

    // 3: zero halt opcode, PC wraps 3 -> 0
    do_reset();
    foreach (mem_b[i]) q_b.push_back(mem_b[i]);
    q_b.push_back(8'h11);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q_b.size() == 0) break;
      tick();
    end
    inst_ready = 1'b0;
    check("t3_sb_empty", q_b.size(), 32'd0);
    check("t3_count", {16'd0, count_b}, 32'd5);

    // 4: branch flushes a pending word
    do_reset();
    q_a.push_back(8'h11);
    start_pulse_a();
    tick();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("t4_pending", {24'd0, out_a}, 32'h22);
    branch_valid = 1'b1; branch_target = 2'd3;
    tick();
    branch_valid = 1'b0;
    check("t4_flush_valid", {31'd0, valid_a}, 32'd0);
    check("t4_flush_pc",    {30'd0, pc_a},    32'd3);
    check("t4_flush_count", {16'd0, count_a}, 32'd1);
    q_a.push_back(8'h44); q_a.push_back(8'h11); q_a.push_back(8'h22);
    inst_ready = 1'b1;
    wait_halted_a(20);
    check("t4_count", {16'd0, count_a}, 32'd4);
    check("t4_sb_empty", q_a.size(), 32'd0);

    // 5: branch out of HALT
    branch_valid = 1'b1; branch_target = 2'd0;
    tick();
    branch_valid = 1'b0;
    check("t5_halted", {31'd0, halted_a}, 32'd0);
    check("t5_busy",   {31'd0, busy_a},   32'd1);
    q_a.push_back(8'h11); q_a.push_back(8'h22);
    tick();
    check("t5_valid", {31'd0, valid_a}, 32'd1);
    check("t5_word",  {24'd0, out_a},   32'h11);
    wait_halted_a(20);
    check("t5_sb_empty", q_a.size(), 32'd0);

    // 6: reset during a stall
    do_reset();
    inst_ready = 1'b0;
    start_pulse_a();
    tick();
    tick();
    check("t6_stalled", {31'd0, valid_a}, 32'd1);
    do_reset();
    check("t6_busy",  {31'd0, busy_a},  32'd0);
    check("t6_valid", {31'd0, valid_a}, 32'd0);
    check("t6_pc",    {30'd0, pc_a},    32'd0);
    check("t6_count", {16'd0, count_a}, 32'd0);
    q_a.push_back(8'h11); q_a.push_back(8'h22);
    inst_ready = 1'b1;
    start_pulse_a();
    wait_halted_a(20);
    check("t6_count_after", {16'd0, count_a}, 32'd2);
    check("t6_sb_empty", q_a.size(), 32'd0);

    // Counter saturation on the free-running zero-halt instance
    do_reset();
    mon_b_en = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (65540) tick();
    check("sat_count", {16'd0, count_b}, 32'hFFFF);
    check("sat_busy",  {31'd0, busy_b},  32'd1);
    inst_ready = 1'b0;
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
